// File: rtl/bus_cycle_stepper.sv
// 68000 bus-cycle stepper: withholds ACK so the front panel can free-run, single-step,
// burst N cycles or stop at an address breakpoint. All state moves on the falling MCLK edge.
//
// state | meaning
// IDLE  | no bus cycle in progress, ACK low
// HOLD  | REQ_IN high, ACK withheld (CPU stalled)
// ACKED | ACK asserted, waiting for REQ_IN to drop
module bus_cycle_stepper #(
  parameter int ADDR_WIDTH      = 24,
  parameter int COUNT_WIDTH     = 8,
  parameter int CYCLE_WIDTH     = 16,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                   MCLK_IN,
  input  logic                   RESET_IN,
  input  logic [1:0]             MODE_IN,
  input  logic                   STEP_IN,
  input  logic                   REQ_IN,
  input  logic [ADDR_WIDTH-1:0]  ADDR_IN,
  input  logic [ADDR_WIDTH-1:0]  BP_ADDR_IN,
  input  logic [ADDR_WIDTH-1:0]  BP_MASK_IN,
  input  logic [COUNT_WIDTH-1:0] COUNT_IN,
  output logic                   ACK,
  output logic                   PAUSED,
  output logic                   BP_HIT,
  output logic [COUNT_WIDTH-1:0] REMAIN,
  output logic [CYCLE_WIDTH-1:0] CYCLE_COUNT
);

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_STEP  = 2'd1;
  localparam logic [1:0] MODE_BURST = 2'd2;
  localparam logic [1:0] MODE_BREAK = 2'd3;
  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, ACKED} state_t;

  state_t                 state;
  logic                   sync_1, sync_2, deb_level;
  logic [DBW-1:0]         deb_cnt;
  logic                   deb_done, step_event;
  logic [COUNT_WIDTH-1:0] count_eff, burst_avail;
  logic                   addr_match, grant, take;

  // deb_cnt holds how many consecutive samples already disagreed with deb_level
  assign deb_done   = (sync_2 != deb_level) && (deb_cnt == DBW'(DEBOUNCE_CYCLES - 1));
  assign step_event = deb_done && sync_2;

  always_ff @(negedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_1 <= STEP_IN;
      sync_2 <= sync_1;
      if (sync_2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        deb_level <= sync_2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DBW'(1);
      end
    end
  end

  always_comb begin
    count_eff   = (COUNT_IN == '0) ? COUNT_WIDTH'(1) : COUNT_IN;
    burst_avail = '0;
    if (MODE_IN == MODE_BURST)
      burst_avail = (REMAIN == '0 && step_event) ? count_eff : REMAIN;
    addr_match = ((ADDR_IN ^ BP_ADDR_IN) & BP_MASK_IN) == '0;
    grant = 1'b0;
    case (MODE_IN)
      MODE_RUN:   grant = 1'b1;
      MODE_STEP:  grant = (state == HOLD) && step_event;
      MODE_BURST: grant = (burst_avail != '0);
      MODE_BREAK: grant = (state == IDLE) ? !addr_match : step_event;
      default:    grant = 1'b0;
    endcase
    take = REQ_IN && (state != ACKED) && grant;
  end

  always_ff @(negedge MCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state       <= IDLE;
      ACK         <= 1'b0;
      PAUSED      <= 1'b0;
      BP_HIT      <= 1'b0;
      REMAIN      <= '0;
      CYCLE_COUNT <= '0;
    end else begin
      BP_HIT <= 1'b0;
      REMAIN <= (take && MODE_IN == MODE_BURST) ? burst_avail - COUNT_WIDTH'(1) : burst_avail;
      case (state)
        IDLE: begin
          if (REQ_IN) begin
            BP_HIT <= (MODE_IN == MODE_BREAK) && addr_match;
            if (take) begin
              state <= ACKED;
              ACK   <= 1'b1;
            end else begin
              state  <= HOLD;
              PAUSED <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!REQ_IN) begin
            state  <= IDLE;
            PAUSED <= 1'b0;
          end else if (take) begin
            state  <= ACKED;
            ACK    <= 1'b1;
            PAUSED <= 1'b0;
          end
        end
        ACKED: begin
          if (!REQ_IN) begin
            state       <= IDLE;
            ACK         <= 1'b0;
            CYCLE_COUNT <= CYCLE_COUNT + CYCLE_WIDTH'(1);
          end
        end
        default: begin
          state  <= IDLE;
          ACK    <= 1'b0;
          PAUSED <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_cycle_stepper.md
# bus_cycle_stepper

Parametrised bus-cycle stepper for the 68000 bus. It sits between the bus-cycle decoder's request (REQ_IN) and the DTACK generator (ACK), and withholds ACK to stall the CPU under front-panel control. It supports four modes:
- free run;
- single-step;
- N-cycle burst;
- run-to-address breakpoint.

It also provides an internal step-switch synchroniser/debouncer and a completed-cycle counter.

## Interface
- ADDR_WIDTH, 24, width of bus address and breakpoint compare
- COUNT_WIDTH, 8, width of burst count and REMAIN
- CYCLE_WIDTH, 16, width of completed-cycle counter
- DEBOUNCE_CYCLES, 1024, consecutive stable MCLK samples required to accept a STEP_IN level change (≥2)

- MCLK_IN  in  1  bus clock; all state updates on the falling edge
- RESET_IN  in  1  asynchronous, active-high reset
- MODE_IN  in  2  0=RUN, 1=STEP, 2=BURST, 3=BREAK; sampled every edge
- STEP_IN  in  1  raw step switch, asynchronous, active-high
- REQ_IN  in  1  bus cycle in progress, same clock domain
- ADDR_IN  in  ADDR_WIDTH  bus address, valid while REQ_IN high
- BP_ADDR_IN  in  ADDR_WIDTH  breakpoint address
- BP_MASK_IN  in  ADDR_WIDTH  compare mask (1 = bit compared)
- COUNT_IN  in  COUNT_WIDTH  burst length; 0 is treated as 1
- ACK  out  1  cycle acknowledge to DTACK logic
- PAUSED  out  1  REQ_IN high and ACK withheld (CPU stalled)
- BP_HIT  out  1  one-edge pulse on breakpoint match
- REMAIN  out  COUNT_WIDTH  burst cycles still granted
- CYCLE_COUNT  out  CYCLE_WIDTH  acknowledged bus cycles, wraps

## Operation
Reset: ACK=0, PAUSED=0, BP_HIT=0, REMAIN=0, CYCLE_COUNT=0. The FSM is in IDLE, the sync flops and debounced level are 0, and the debounce counter is 0. Reset applies immediately, including mid-cycle.

Step path:
- STEP_IN passes through a 2-flop synchroniser.
- The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it.
- A step event is the single edge at which the debounced level goes 0→1.
- The switch must release (debounced 0) before another event can occur.

FSM states:
- IDLE: REQ_IN low, ACK low. When REQ_IN is sampled high, the edge evaluates the grant (see below). Granted → ACKED. Not granted → HOLD.
- HOLD: PAUSED=1. A grant is re-evaluated every edge. On grant → ACKED. If REQ_IN drops → IDLE (no ACK, no count).
- ACKED: ACK=1. When REQ_IN is sampled low, ACK is negated at that same edge, CYCLE_COUNT increments, and the FSM returns to IDLE. ACK is never re-asserted without an intervening edge with REQ_IN low.

Grant rules, evaluated per edge with REQ_IN high:
- RUN: always grant.
- STEP: grant only on a step event at an edge while in HOLD. Step events at any other time are discarded (no pre-arming).
- BURST:
  - A step event while REMAIN=0 loads REMAIN=max(COUNT_IN,1).
  - Grant when REMAIN>0; REMAIN decrements at the granting edge.
  - A load and a grant at the same edge yield REMAIN=max(COUNT_IN,1)-1.
  - Step events while REMAIN>0 are ignored.
  - Leaving BURST clears REMAIN to 0.
- BREAK:
  - In IDLE at the REQ rising sample, compute the match (ADDR_IN^BP_ADDR_IN)&BP_MASK_IN==0.
  - No match → grant.
  - Match → BP_HIT pulses for one edge, the FSM enters HOLD, and the cycle behaves as STEP: a step event grants it, then free run resumes.
  - An all-zero mask matches every cycle.

A MODE_IN change takes effect at the next edge. A HOLD with MODE_IN changed to RUN grants at that edge.

## Timing
- RUN latency: REQ_IN sampled high at falling edge k → ACK high after edge k (zero added waits).
- Step latency: raw STEP_IN rise → event after 2 sync + DEBOUNCE_CYCLES edges. ACK rises at the event edge if in HOLD.
- ACK falls at the first falling edge that samples REQ_IN low. CYCLE_COUNT updates at the same edge.
- PAUSED is registered and equals (state==HOLD).
- BP_HIT is high for exactly the edge-to-edge interval after the matching sample.
- CYCLE_COUNT wraps from 2^CYCLE_WIDTH-1 to 0.

## Test plan
- Reset mid-ACKED: assert RESET_IN with ACK=1 → ACK, PAUSED, REMAIN, and CYCLE_COUNT are 0 immediately; FSM in IDLE after release.
- RUN, 5 back-to-back REQ pulses of 3 clocks, 1-clock gaps → ACK 1 edge after each REQ rise, CYCLE_COUNT=5, PAUSED never 1.
- STEP, DEBOUNCE_CYCLES=4, STEP_IN bouncing 3 toggles in 3 clocks then stable high → exactly one ACK, only after 2+4 stable edges. STEP_IN pressed while IDLE → no ACK on the next REQ.
- BURST, COUNT_IN=3, one step, 5 REQs → cycles 1-3 acked, REMAIN 2→1→0, cycles 4-5 PAUSED. COUNT_IN=0 → exactly 1 cycle.
- BREAK, BP_ADDR_IN=0x001000, BP_MASK_IN=0xFFFFF0, addresses 0x000FFE, 0x00100C, 0x001010 → first acked; second pauses with BP_HIT pulse and is acked only on a step; third acked free.
- HOLD in STEP, MODE_IN→RUN → ACK at the next edge. REQ_IN dropped in HOLD → IDLE, CYCLE_COUNT unchanged. CYCLE_WIDTH=4, 17 cycles → CYCLE_COUNT=1.
